// File: rtl/isa_prefetch_buffer.sv
// Instruction prefetch buffer: caches one ISA_DEPTH-long window of instructions fetched by DDR burst.
// Optional ISA_CRITICAL_WORD_EN forwards the missed instruction as soon as the first burst word lands.
module isa_prefetch_buffer #(
    parameter int DDR_ADDR_WIDTH = 28,
    parameter int ISA_WIDTH      = 30,
    parameter int ISA_DEPTH      = 72,
    parameter int PC_WIDTH       = 16,
    parameter int ADDR_STRIDE    = 8
) (
    input  logic                      mem_clk,
    input  logic                      rst_n,
    input  logic                      fetch_req,
    input  logic [PC_WIDTH-1:0]       pc,
    output logic                      fetch_ready,
    output logic                      ins_valid,
    output logic [ISA_WIDTH-1:0]      instruction,
    input  logic                      ddr_rdy,
    output logic                      ISA_read_req,
    output logic [DDR_ADDR_WIDTH-1:0] ISA_read_addr,
    output logic [9:0]                isa_read_len,
    input  logic [ISA_WIDTH-1:0]      instruction_to_cache,
    input  logic [9:0]                rd_cnt_isa
);
    localparam int IW  = (ISA_DEPTH > 1) ? $clog2(ISA_DEPTH) : 1;
    localparam int PW1 = PC_WIDTH + 1;

    localparam logic [2:0] WAIT_RDY = 3'd0;
    localparam logic [2:0] IDLE     = 3'd1;
    localparam logic [2:0] REQ      = 3'd2;
    localparam logic [2:0] FILL     = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;

    logic [2:0]           state;
    logic [PC_WIDTH-1:0]  wbase;
    logic                 win_vld;
    logic [9:0]           rd_cnt_q;
    logic [ISA_WIDTH-1:0] isa_buf [ISA_DEPTH];

    logic [PC_WIDTH:0]    pc_ext, wbase_ext, wlast_ext;
    logic                 hit, word_new, word_ok;
    logic [IW-1:0]        rd_idx, wr_idx;

    // Window compare is one bit wider than pc so a window near the top of the pc range never wraps.
    assign pc_ext    = {1'b0, pc};
    assign wbase_ext = {1'b0, wbase};
    assign wlast_ext = wbase_ext + PW1'(ISA_DEPTH - 1);
    assign hit       = win_vld && (pc_ext >= wbase_ext) && (pc_ext <= wlast_ext);
    assign rd_idx    = IW'(pc - wbase);
    assign wr_idx    = IW'(rd_cnt_isa - 10'd1);

    // A word arrives whenever the DDR count steps to a new nonzero value.
    assign word_new  = (rd_cnt_isa != rd_cnt_q) && (rd_cnt_isa != 10'd0);
    assign word_ok   = word_new && (rd_cnt_isa <= 10'(ISA_DEPTH)) &&
                       ((state == REQ) || (state == FILL));

    assign fetch_ready = (state == IDLE) && ddr_rdy;

    always_ff @(posedge mem_clk) begin
        if (word_ok)
            isa_buf[wr_idx] <= instruction_to_cache;
    end

`ifdef ISA_CRITICAL_WORD_EN
    logic crit_sent;
`endif

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= WAIT_RDY;
            wbase         <= '0;
            win_vld       <= 1'b0;
            rd_cnt_q      <= '0;
            instruction   <= '0;
            ins_valid     <= 1'b0;
            ISA_read_req  <= 1'b0;
            ISA_read_addr <= '0;
            isa_read_len  <= '0;
`ifdef ISA_CRITICAL_WORD_EN
            crit_sent     <= 1'b0;
`endif
        end else begin
            rd_cnt_q  <= rd_cnt_isa;
            ins_valid <= 1'b0;
            if (!ddr_rdy) begin
                state        <= WAIT_RDY;
                win_vld      <= 1'b0;
                ISA_read_req <= 1'b0;
            end else begin
                case (state)
                    WAIT_RDY: if (rd_cnt_isa == 10'd0) state <= IDLE;
                    IDLE: if (fetch_req) begin
                        if (hit) begin
                            instruction <= isa_buf[rd_idx];
                            ins_valid   <= 1'b1;
                        end else begin
                            wbase         <= pc;
                            win_vld       <= 1'b0;
                            ISA_read_req  <= 1'b1;
                            ISA_read_addr <= DDR_ADDR_WIDTH'(pc) * DDR_ADDR_WIDTH'(ADDR_STRIDE);
                            isa_read_len  <= 10'(ISA_DEPTH);
                            state         <= REQ;
`ifdef ISA_CRITICAL_WORD_EN
                            crit_sent     <= 1'b0;
`endif
                        end
                    end
                    REQ: if (rd_cnt_isa != 10'd0) begin
                        ISA_read_req <= 1'b0;
                        state        <= FILL;
                    end
                    // A count falling back to zero before the last word means the burst was cut short.
                    FILL: if (rd_cnt_isa == 10'd0) begin
                        ISA_read_req <= 1'b1;
                        state        <= REQ;
                    end else if (word_ok && (rd_cnt_isa == 10'(ISA_DEPTH))) begin
                        state <= DONE;
                    end
                    DONE: begin
                        win_vld <= 1'b1;
                        state   <= IDLE;
`ifdef ISA_CRITICAL_WORD_EN
                        if (!crit_sent) begin
                            instruction <= isa_buf[0];
                            ins_valid   <= 1'b1;
                        end
`else
                        instruction <= isa_buf[0];
                        ins_valid   <= 1'b1;
`endif
                    end
                    default: state <= WAIT_RDY;
                endcase
`ifdef ISA_CRITICAL_WORD_EN
                // Burst word 1 is the missed pc; hand it over once, even across a reissued burst.
                if (word_ok && (rd_cnt_isa == 10'd1) && !crit_sent) begin
                    instruction <= instruction_to_cache;
                    ins_valid   <= 1'b1;
                    crit_sent   <= 1'b1;
                end
`endif
            end
        end
    end
endmodule

// File: tb/tb_isa_prefetch_buffer.sv
// Directed bench for isa_prefetch_buffer: expected instructions go into a queue, a monitor pops on ins_valid.
module tb_isa_prefetch_buffer;
    logic        mem_clk = 1'b0;
    logic        rst_n;
    logic        fetch_req;
    logic [15:0] pc;
    logic        fetch_ready;
    logic        ins_valid;
    logic [29:0] instruction;
    logic        ddr_rdy;
    logic        ISA_read_req;
    logic [27:0] ISA_read_addr;
    logic [9:0]  isa_read_len;
    logic [29:0] instruction_to_cache;
    logic [9:0]  rd_cnt_isa;

    int errors = 0;
    int checks = 0;
    logic [29:0] exp_q[$];

    isa_prefetch_buffer dut (
        .mem_clk(mem_clk), .rst_n(rst_n), .fetch_req(fetch_req), .pc(pc),
        .fetch_ready(fetch_ready), .ins_valid(ins_valid), .instruction(instruction),
        .ddr_rdy(ddr_rdy), .ISA_read_req(ISA_read_req), .ISA_read_addr(ISA_read_addr),
        .isa_read_len(isa_read_len), .instruction_to_cache(instruction_to_cache),
        .rd_cnt_isa(rd_cnt_isa)
    );

    always #5 mem_clk = ~mem_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every ins_valid pulse must match the oldest outstanding expectation.
    always @(negedge mem_clk) begin
        if (rst_n === 1'b1 && ins_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got %0h expected no ins_valid", instruction);
            end else begin
                logic [29:0] e;
                e = exp_q.pop_front();
                chk("sb_instruction", 32'(instruction), 32'(e));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic fetch(input logic [15:0] pc_v);
        bit ok = 0;
        fetch_req = 1'b1;
        pc = pc_v;
        for (int i = 0; i < 300; i++) begin
            @(negedge mem_clk);
            if (fetch_ready) begin ok = 1; break; end
        end
        @(posedge mem_clk); #1;
        fetch_req = 1'b0;
        chk("fetch_accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_req(input string name, input logic [27:0] addr);
        bit seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge mem_clk);
            if (ISA_read_req) begin seen = 1; break; end
        end
        chk({name, "_req"}, 32'(seen), 32'd1);
        chk({name, "_addr"}, 32'(ISA_read_addr), 32'(addr));
        chk({name, "_len"}, 32'(isa_read_len), 32'd72);
        @(posedge mem_clk); #1;
    endtask

    // Deliver words 1..last; fetch_ready must stay low throughout. Optionally drop the count to 0 after.
    task automatic burst(input logic [29:0] base, input int last, input bit zero_after);
        int bad = 0;
        for (int k = 1; k <= last; k++) begin
            @(posedge mem_clk); #1;
            rd_cnt_isa = 10'(k);
            instruction_to_cache = base + 30'(k - 1);
            @(negedge mem_clk);
            if (fetch_ready !== 1'b0) bad++;
        end
        chk("busy_ready_low", 32'(bad), 32'd0);
        if (zero_after) begin
            @(posedge mem_clk); #1;
            rd_cnt_isa = 10'd0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        int bad;
        rst_n = 1'b0; ddr_rdy = 1'b0; fetch_req = 1'b0; pc = '0;
        rd_cnt_isa = '0; instruction_to_cache = '0;
        repeat (3) @(negedge mem_clk);
        chk("rst_fetch_ready", 32'(fetch_ready), 32'd0);
        chk("rst_ins_valid", 32'(ins_valid), 32'd0);
        chk("rst_instruction", 32'(instruction), 32'd0);
        chk("rst_req", 32'(ISA_read_req), 32'd0);
        chk("rst_addr", 32'(ISA_read_addr), 32'd0);
        chk("rst_len", 32'(isa_read_len), 32'd0);
        @(posedge mem_clk); #1;
        rst_n = 1'b1; ddr_rdy = 1'b1;
        repeat (2) @(posedge mem_clk);
        @(negedge mem_clk);
        chk("idle_ready", 32'(fetch_ready), 32'd1);
        @(posedge mem_clk); #1;

        // Cold miss at pc 0, with a second fetch held during the fill.
        exp_q.push_back(30'h100);
        exp_q.push_back(30'h105);
        fetch(16'd0);
        fetch_req = 1'b1; pc = 16'd5;
        wait_req("cold", 28'h0);
        burst(30'h100, 72, 1);
        fetch(16'd5);

        // Hit at the last window line.
        exp_q.push_back(30'h147);
        fetch(16'd71);
        @(negedge mem_clk);
        chk("hit_latency", 32'(ins_valid), 32'd1);
        chk("hit_instruction", 32'(instruction), 32'h147);
        bad = 0;
        repeat (4) begin
            @(negedge mem_clk);
            if (ISA_read_req !== 1'b0) bad++;
        end
        chk("hit_no_req", 32'(bad), 32'd0);
        @(posedge mem_clk); #1;

        // First pc past the window misses and rebases.
        exp_q.push_back(30'h200);
        fetch(16'd72);
        wait_req("bound", 28'h240);
        burst(30'h200, 72, 1);
        exp_q.push_back(30'h247);
        fetch(16'd143);
        repeat (3) @(posedge mem_clk); #1;

        // Burst aborted at 30 words: same address requested again.
        exp_q.push_back(30'h300);
        fetch(16'd200);
        wait_req("abort", 28'h640);
        burst(30'h600, 30, 1);
        wait_req("reissue", 28'h640);
        burst(30'h300, 72, 1);
        repeat (3) @(posedge mem_clk); #1;

        // Reset in the middle of a fill; the accepted fetch is dropped.
        fetch(16'd400);
        wait_req("midrst", 28'hC80);
        burst(30'h500, 40, 0);
        @(posedge mem_clk); #1;
        rst_n = 1'b0;
        @(negedge mem_clk);
        chk("midrst_req_low", 32'(ISA_read_req), 32'd0);
        chk("midrst_ready_low", 32'(fetch_ready), 32'd0);
        @(posedge mem_clk); #1;
        rd_cnt_isa = 10'd41; rst_n = 1'b1;
        bad = 0;
        for (int k = 42; k <= 72; k++) begin
            @(negedge mem_clk);
            if (ISA_read_req !== 1'b0 || fetch_ready !== 1'b0) bad++;
            @(posedge mem_clk); #1;
            rd_cnt_isa = 10'(k);
        end
        @(negedge mem_clk);
        if (ISA_read_req !== 1'b0 || fetch_ready !== 1'b0) bad++;
        chk("midrst_wait", 32'(bad), 32'd0);
        @(posedge mem_clk); #1;
        rd_cnt_isa = 10'd0;
        exp_q.push_back(30'h400);
        fetch(16'd10);
        wait_req("postrst", 28'h50);
        burst(30'h400, 72, 1);

        repeat (5) @(posedge mem_clk);
        @(negedge mem_clk);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/isa_prefetch_buffer.md
ISA_PREFETCH_BUFFER -- requirements
Module: isa_prefetch_buffer

Interface
REQ-001 SHALL have parameter DDR_ADDR_WIDTH, default 28: DDR byte-address width.
REQ-002 SHALL have parameter ISA_WIDTH, default 30: instruction width.
REQ-003 SHALL have parameter ISA_DEPTH, default 72: buffer lines, which is also the burst length requested.
REQ-004 SHALL have parameter PC_WIDTH, default 16: instruction-index width.
REQ-005 SHALL have parameter ADDR_STRIDE, default 8: DDR address step per instruction.
REQ-006 SHALL have port mem_clk, input, 1 bit: sole clock.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port fetch_req, input, 1 bit: core requests the instruction at pc.
REQ-009 SHALL have port pc, input, PC_WIDTH bits: instruction index.
REQ-010 SHALL have port fetch_ready, output, 1 bit: a fetch_req is accepted this cycle.
REQ-011 SHALL have port ins_valid, output, 1 bit: one-cycle pulse; instruction is valid.
REQ-012 SHALL have port instruction, output, ISA_WIDTH bits: fetched instruction.
REQ-013 SHALL have port ddr_rdy, input, 1 bit: DDR preload done; DDR is usable.
REQ-014 SHALL have port ISA_read_req, output, 1 bit: burst-read request to the DDR interface.
REQ-015 SHALL have port ISA_read_addr, output, DDR_ADDR_WIDTH bits: burst start address.
REQ-016 SHALL have port isa_read_len, output, 10 bits: burst length.
REQ-017 SHALL have port instruction_to_cache, input, ISA_WIDTH bits: registered DDR read word.
REQ-018 SHALL have port rd_cnt_isa, input, 10 bits: words received so far in the current burst; 0 when no burst is active.

Function
REQ-019 SHALL implement FSM states WAIT_RDY, IDLE, REQ, FILL, DONE.
REQ-020 SHALL move WAIT_RDY->IDLE when ddr_rdy=1 and rd_cnt_isa=0.
REQ-021 SHALL hold a window base register wbase and a window valid flag win_vld; a hit is win_vld=1 and wbase <= pc <= wbase+ISA_DEPTH-1, compared at PC_WIDTH+1 bits with no wrap.
REQ-022 SHALL assert fetch_ready only in IDLE.
REQ-023 SHALL, on an IDLE hit, register buf[pc-wbase] to instruction and pulse ins_valid on the next edge (latency 1).
REQ-024 SHALL, on an IDLE miss, latch pc into wbase, clear win_vld and go to REQ.
REQ-025 SHALL, in REQ, hold ISA_read_req=1 with ISA_read_addr = wbase*ADDR_STRIDE (zero-extended) and isa_read_len = ISA_DEPTH, until rd_cnt_isa != 0 is seen, then drop the request and go to FILL.
REQ-026 SHALL treat a word as received when rd_cnt_isa differs from its value one cycle earlier and is nonzero; the word is written to buf[rd_cnt_isa-1].
REQ-027 SHALL ignore words with rd_cnt_isa > ISA_DEPTH.
REQ-028 SHALL go FILL->DONE when word ISA_DEPTH is written.
REQ-029 SHALL, in DONE, set win_vld=1, return buf[0] with an ins_valid pulse (unless it was already delivered per REQ-042), then go to IDLE.
REQ-030 SHALL ignore fetch_req outside IDLE; the core holds the request until fetch_ready=1.
REQ-031 SHALL, if rd_cnt_isa returns to 0 in FILL before ISA_DEPTH words arrive, leave win_vld at 0 and re-enter REQ with the same wbase.
REQ-032 SHALL, if ddr_rdy falls, go to WAIT_RDY and clear win_vld.
REQ-033 SHALL take ISA_read_req and isa_read_len directly from registers (no combinational path from inputs).

Reset
REQ-034 SHALL, on rst_n=0, enter WAIT_RDY immediately.
REQ-035 SHALL, on reset, force win_vld=0, wbase=0, instruction=0, ins_valid=0, fetch_ready=0, ISA_read_req=0, ISA_read_addr=0, isa_read_len=0.
REQ-036 SHALL leave buffer RAM contents unreset.
REQ-037 SHALL, after reset is released mid-burst, wait in WAIT_RDY until rd_cnt_isa=0 before issuing any request.

Configuration
REQ-038 SHALL use macro ISA_CRITICAL_WORD_EN.
REQ-039 SHALL, with ISA_CRITICAL_WORD_EN defined, forward the first burst word (buf[0], the missed pc) to instruction with an ins_valid pulse one cycle after it is received in FILL.
REQ-040 SHALL, with ISA_CRITICAL_WORD_EN defined, keep fetch_ready=0 until DONE.
REQ-041 SHALL, with ISA_CRITICAL_WORD_EN undefined, return the missed instruction only in DONE.
REQ-042 SHALL pulse ins_valid exactly once per accepted fetch in both configurations.

Verification
REQ-043 SHALL cover cold miss: ddr_rdy=1, fetch pc=0 -> ISA_read_req=1, addr=0, len=72; 72 words 0x100+k -> instruction=0x100, a single ins_valid pulse.
REQ-044 SHALL cover hit after fill: fetch pc=71 -> instruction=0x147 one cycle later, no ISA_read_req.
REQ-045 SHALL cover boundary: fetch pc=72 -> miss, ISA_read_addr=0x240, wbase=72.
REQ-046 SHALL cover busy: fetch_req held during FILL -> fetch_ready=0 and no second request until IDLE.
REQ-047 SHALL cover aborted burst: rd_cnt_isa drops to 0 at count 30 -> request reissued with the same address, win_vld stays 0.
REQ-048 SHALL cover reset mid-fill: rst_n low at count 40, released while rd_cnt_isa=41 -> no request until rd_cnt_isa=0, then a miss on the next fetch.
